mantissa_oaud: RTL and testbench

MANTISSA_OAUD -- requirements
Module: mantissa_oaud

---
 rtl/mantissa_oaud.sv | 140 ++++++++++++++
 tb/tb_mantissa_oaud.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mantissa_oaud.sv
// -----------------------------------------------------------------------------
// mantissa_oaud
//   Iterative restoring divider for normalized floating-point mantissas.
//   Computes (1.X) / (1.Y) one quotient bit per clock, MSB first. If the
//   dividend is smaller than the divisor, it is doubled up front so the
//   quotient always lands in [1,2). Shift reports that doubling, and the
//   caller must then decrement the result exponent by one.
//
//   Handshake: the block accepts operands only in IDLE (in_ready). It holds
//   the result in DONE (out_valid) until out_ready is seen on a clock edge.
//
// Parameters
//   BASELINE       bit index base of mantissa fields (MSB index = BASELINE-1)
//   MANTISSA_WIDTH stored fraction bits per operand (hidden 1 implied)
//   ITERATIONS     quotient bits computed, 1..MANTISSA_WIDTH+1
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   in_valid      operand pair offered
//   in_ready      block idle and can accept operands
//   Mantissa_X    dividend fraction (value 1.X)
//   Mantissa_Y    divisor fraction  (value 1.Y)
//   out_valid     result held and valid
//   out_ready     consumer takes result
//   Mantissa_Out  normalized quotient fraction, truncated
//   Shift         1 = quotient pre-doubled, exponent must be decremented
// -----------------------------------------------------------------------------
module mantissa_oaud #(
  parameter int BASELINE       = 15,
  parameter int MANTISSA_WIDTH = 15,
  parameter int ITERATIONS     = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [BASELINE-1:BASELINE-MANTISSA_WIDTH]  Mantissa_X,
  input  logic [BASELINE-1:BASELINE-MANTISSA_WIDTH]  Mantissa_Y,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [BASELINE-1:BASELINE-MANTISSA_WIDTH]  Mantissa_Out,
  output logic                                       Shift
);

  localparam int FW = MANTISSA_WIDTH + 1;          // fraction plus hidden bit
  localparam int RW = MANTISSA_WIDTH + 3;          // remainder width
  localparam int CW = $clog2(ITERATIONS + 1);      // iteration counter width

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    r_state;
  logic [CW-1:0]             r_cnt;
  logic [RW-1:0]             r_rem;
  logic [FW-1:0]             r_yf;
  logic [MANTISSA_WIDTH-1:0] r_quot;
  logic                      r_shift;

  logic [FW-1:0] w_xf;
  logic [FW-1:0] w_yf;
  logic          w_q;
  logic [RW-1:0] w_rem_sub;
  logic [RW-1:0] w_rem_next;

  assign w_xf = {1'b1, Mantissa_X};
  assign w_yf = {1'b1, Mantissa_Y};

  // One restoring step: subtract if it fits, then shift left. The remainder
  // stays below 2*Yf, so the bit shifted out at the top is always zero.
  assign w_q        = (r_rem >= {2'b00, r_yf});
  assign w_rem_sub  = w_q ? (r_rem - {2'b00, r_yf}) : r_rem;
  assign w_rem_next = {w_rem_sub[RW-2:0], 1'b0};

  assign in_ready     = (r_state == S_IDLE);
  assign out_valid    = (r_state == S_DONE);
  assign Mantissa_Out = r_quot;
  assign Shift        = r_shift;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the values from before the edge.
  // NOTE: the datapath registers are reset as well, because the outputs must
  // read zero while reset is held, not merely once the FSM restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_yf    <= '0;
      r_quot  <= '0;
      r_shift <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_yf   <= w_yf;
            r_cnt  <= '0;
            r_quot <= '0;
            // Pre-double a small dividend so the integer quotient bit is 1.
            if (w_xf >= w_yf) begin
              r_rem   <= {2'b00, w_xf};
              r_shift <= 1'b0;
            end else begin
              r_rem   <= {1'b0, w_xf, 1'b0};
              r_shift <= 1'b1;
            end
            r_state <= S_CALC;
          end
        end

        S_CALC: begin
          r_rem <= w_rem_next;
          r_cnt <= r_cnt + 1'b1;
          // Bit 0 is the integer bit (always 1) and is dropped. Bit k lands at
          // fraction position MANTISSA_WIDTH-k. Untouched LSBs stay zero.
          for (int i = 0; i < MANTISSA_WIDTH; i++) begin
            if ((r_cnt != '0) && (i == MANTISSA_WIDTH - int'(r_cnt))) begin
              r_quot[i] <= w_q;
            end
          end
          if (r_cnt == CW'(ITERATIONS - 1)) begin
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mantissa_oaud.sv
// -----------------------------------------------------------------------------
// tb_mantissa_oaud
//   Bench for mantissa_oaud. One instance uses ITERATIONS=16 and carries
//   most of the tests. A second instance with ITERATIONS=8 covers the
//   truncated case. Expected results come from an arithmetic model,
//   floor(num * 2^(it-1) / Yf), and are queued when operands are accepted.
//   They are popped when a result is taken.
// -----------------------------------------------------------------------------
module tb_mantissa_oaud;

  localparam int MW     = 15;
  localparam int N_RAND = 2000;

  logic clk;
  logic rst;

  logic          iv16, ir16, ov16, or16, sh16;
  logic [MW-1:0] x16, y16, mo16;
  logic          iv8, ir8, ov8, or8, sh8;
  logic [MW-1:0] x8, y8, mo8;

  int n_vec  = 0;
  int n_miss = 0;

  logic [15:0] exp_q[$];

  mantissa_oaud #(.BASELINE(15), .MANTISSA_WIDTH(MW), .ITERATIONS(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(iv16), .in_ready(ir16),
    .Mantissa_X(x16), .Mantissa_Y(y16),
    .out_valid(ov16), .out_ready(or16),
    .Mantissa_Out(mo16), .Shift(sh16)
  );

  mantissa_oaud #(.BASELINE(15), .MANTISSA_WIDTH(MW), .ITERATIONS(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .Mantissa_X(x8), .Mantissa_Y(y8),
    .out_valid(ov8), .out_ready(or8),
    .Mantissa_Out(mo8), .Shift(sh8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_miss++;
      $display("FAIL %s: got=%h exp=%h", tag, got, expv);
    end
  endtask

  // Returns {Shift, Mantissa_Out} for quotient width it.
  function automatic logic [15:0] model(input logic [MW-1:0] x, input logic [MW-1:0] y,
                                        input int it);
    longint xf, yf, num, q, frac;
    logic   sh;
    xf = 64'd32768 + longint'(x);
    yf = 64'd32768 + longint'(y);
    if (xf >= yf) begin num = xf;     sh = 1'b0; end
    else          begin num = 2 * xf; sh = 1'b1; end
    q    = (num << (it - 1)) / yf;
    frac = (q - (longint'(1) << (it - 1))) << (MW - (it - 1));
    return {sh, frac[MW-1:0]};
  endfunction

  // Offer operands at a negedge. Returns at the negedge after the accept edge.
  task automatic accept16(input logic [MW-1:0] x, input logic [MW-1:0] y);
    int w;
    w = 0;
    while (!ir16 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!ir16) check("accept_ready_timeout", 32'(ir16), 32'd1);
    iv16 = 1'b1;
    x16  = x;
    y16  = y;
    @(negedge clk);
    iv16 = 1'b0;
  endtask

  // Counts edges from the accept edge to out_valid and checks the latency.
  task automatic wait_valid16(input string tag, input int exp_lat);
    int lat;
    lat = 1;
    while (!ov16 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check(tag, 32'(lat - 1), 32'(exp_lat));
  endtask

  task automatic directed16(input string tag, input logic [MW-1:0] x, input logic [MW-1:0] y,
                            input logic [MW-1:0] exp_m, input logic exp_s);
    or16 = 1'b1;
    accept16(x, y);
    wait_valid16({tag, "_lat"}, 16);
    check({tag, "_mant"},  32'(mo16), 32'(exp_m));
    check({tag, "_shift"}, 32'(sh16), 32'(exp_s));
    @(negedge clk);
    check({tag, "_idle"}, 32'(ir16), 32'd1);
  endtask

  initial begin
    int          sent, recv, cyc, lat;
    logic        seen;
    logic [15:0] e;

    rst = 1'b1;
    iv16 = 1'b0; or16 = 1'b1; x16 = '0; y16 = '0;
    iv8  = 1'b0; or8  = 1'b1; x8  = '0; y8  = '0;

    // Reset state while rst is held, before any clock edge.
    #2;
    check("rst_in_ready",  32'(ir16), 32'd1);
    check("rst_out_valid", 32'(ov16), 32'd0);
    check("rst_mant",      32'(mo16), 32'd0);
    check("rst_shift",     32'(sh16), 32'd0);

    // The first accept happens on the first rising edge after release.
    @(negedge clk);
    rst = 1'b0;
    directed16("v00", 15'h0000, 15'h0000, 15'h0000, 1'b0);
    directed16("v40", 15'h4000, 15'h0000, 15'h4000, 1'b0);
    directed16("v1o15", 15'h0000, 15'h4000, 15'h2AAA, 1'b1);
    directed16("vmaxx", 15'h7FFF, 15'h0000, 15'h7FFF, 1'b0);
    directed16("vmaxy", 15'h0000, 15'h7FFF, 15'h0000, 1'b1);
    directed16("veq",   15'h7FFF, 15'h7FFF, 15'h0000, 1'b0);

    // Truncated quotient with ITERATIONS=8.
    iv8 = 1'b1; x8 = 15'h0000; y8 = 15'h4000;
    @(negedge clk);
    iv8 = 1'b0;
    lat = 1;
    while (!ov8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("it8_lat",   32'(lat - 1), 32'd8);
    check("it8_mant",  32'(mo8), 32'h2A00);
    check("it8_shift", 32'(sh8), 32'd1);

    // Backpressure: hold DONE for 10 cycles while input noise is applied.
    or16 = 1'b0;
    accept16(15'h0000, 15'h4000);
    wait_valid16("hold_lat", 16);
    for (int i = 0; i < 10; i++) begin
      iv16 = 1'($urandom_range(0, 1));
      x16  = 15'($urandom);
      y16  = 15'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(ov16), 32'd1);
      check("hold_ready", 32'(ir16), 32'd0);
      check("hold_mant",  32'(mo16), 32'h2AAA);
      check("hold_shift", 32'(sh16), 32'd1);
    end
    iv16 = 1'b0;
    or16 = 1'b1;
    @(negedge clk);
    check("hold_release_ready", 32'(ir16), 32'd1);
    check("hold_release_valid", 32'(ov16), 32'd0);

    // Asynchronous abort after 5 CALC edges.
    accept16(15'h0000, 15'h4000);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_in_ready",  32'(ir16), 32'd1);
    check("abort_out_valid", 32'(ov16), 32'd0);
    check("abort_mant",      32'(mo16), 32'd0);
    check("abort_shift",     32'(sh16), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (ov16) seen = 1'b1;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    directed16("post_abort", 15'h4000, 15'h0000, 15'h4000, 1'b0);

    // Random operands with random backpressure, scored through the queue.
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < N_RAND && cyc < 60000) begin
      or16 = ($urandom_range(0, 3) != 0);
      if (ov16 && or16) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rnd_mant",  32'(mo16), 32'(e[MW-1:0]));
          check("rnd_shift", 32'(sh16), 32'(e[15]));
        end
        recv++;
      end
      if (ir16 && sent < N_RAND) begin
        x16  = 15'($urandom);
        y16  = 15'($urandom);
        iv16 = 1'b1;
        exp_q.push_back(model(x16, y16, 16));
        sent++;
      end else begin
        iv16 = ir16 ? 1'b0 : 1'($urandom_range(0, 1));
        x16  = 15'($urandom);
        y16  = 15'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    iv16 = 1'b0;
    or16 = 1'b1;
    check("rnd_received", 32'(recv), 32'(N_RAND));
    check("rnd_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
